// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and
// hands the fetched instruction to decode over a valid/ready handshake.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  state;
    logic [31:0] fetch_pc;
    logic        drop;
    logic        redirect_bad;

    // A misaligned target halts the stage; HALT ignores every input but rst.
    assign redirect_bad = redirect && (redirect_pc[1:0] != 2'b00) && (state != S_HALT);

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = {fetch_pc[31:2], 2'b00};

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            fetch_pc   <= RESET_PC;
            drop       <= 1'b0;
            misalign   <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            pc         <= RESET_PC;
            pc_plus4   <= RESET_PC + 32'd4;
        end else if (redirect_bad) begin
            misalign   <= 1'b1;
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            state      <= S_HALT;
        end else begin
            case (state)
                S_FETCH: begin
                    state <= S_WAIT;
                    if (redirect) begin
                        drop     <= 1'b1;
                        fetch_pc <= redirect_pc;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        if (imem_rvalid) begin
                            drop  <= 1'b0;
                            state <= S_FETCH;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_FETCH;
                        end else begin
                            inst       <= imem_rdata;
                            pc         <= fetch_pc;
                            pc_plus4   <= fetch_pc + 32'd4;
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        inst_valid <= 1'b0;
                        inst       <= NOP_INST;
                        fetch_pc   <= redirect_pc;
                        state      <= S_FETCH;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        inst       <= NOP_INST;
                        fetch_pc   <= pc_plus4;
                        state      <= S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit; every expected value is a
// hand-computed constant for the cycle being sampled.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    ifetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge; inputs set afterwards
    // apply to the cycle that has just begun.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        tick(); tick();
        check("rst_req",      imem_req,   1);
        check("rst_addr",     imem_addr,  0);
        check("rst_valid",    inst_valid, 0);
        check("rst_inst",     inst,       NOP);
        check("rst_pc",       pc,         0);
        check("rst_pc4",      pc_plus4,   4);
        check("rst_misalign", misalign,   0);
        rst = 1'b0; inst_ready = 1'b1;

        // L=1, always ready: request every 3 cycles at 0, 4.
        tick();
        check("l1_wait_req", imem_req, 0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        check("l1_valid", inst_valid, 1);
        check("l1_inst",  inst,       32'h0050_0093);
        check("l1_pc",    pc,         0);
        check("l1_pc4",   pc_plus4,   4);
        check("l1_hold_req", imem_req, 0);
        tick();
        check("l1_valid_drop", inst_valid, 0);
        check("l1_req2",  imem_req,  1);
        check("l1_addr2", imem_addr, 4);

        // L=5 on address 4, then 4 cycles of backpressure.
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("l5_wait_req", imem_req, 0);
            check("l5_wait_valid", inst_valid, 0);
        end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", inst_valid, 1);
            check("bp_inst",  inst,       32'h00A0_0113);
            check("bp_pc",    pc,         4);
            check("bp_req",   imem_req,   0);
            tick();
        end
        check("bp_still_valid", inst_valid, 1);
        inst_ready = 1'b1;
        tick();
        check("bp_req_next",  imem_req,  1);
        check("bp_addr_next", imem_addr, 8);

        // Redirect to 0x100 in the 2nd WAIT cycle of the fetch from 0x8.
        tick();
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        check("rd_wait_req", imem_req, 0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0008;
        tick();
        imem_rvalid = 1'b0;
        check("rd_dropped_valid", inst_valid, 0);
        check("rd_req",  imem_req,  1);
        check("rd_addr", imem_addr, 32'h0000_0100);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_0193;
        tick();
        imem_rvalid = 1'b0;
        check("rd_valid", inst_valid, 1);
        check("rd_inst",  inst,       32'h0010_0193);
        check("rd_pc",    pc,         32'h0000_0100);
        check("rd_pc4",   pc_plus4,   32'h0000_0104);

        // Redirect to 0x40 in HOLD with inst_ready=1 the same cycle.
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        check("hr_valid", inst_valid, 0);
        check("hr_inst",  inst,       NOP);
        check("hr_addr",  imem_addr,  32'h0000_0040);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0040_0213;
        tick();
        imem_rvalid = 1'b0;
        check("hr_pc",   pc,   32'h0000_0040);
        check("hr_inst2", inst, 32'h0040_0213);

        // Misaligned redirect from HOLD halts until reset.
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        check("ma_flag",  misalign,   1);
        check("ma_valid", inst_valid, 0);
        for (int i = 0; i < 5; i++) begin
            redirect    = (i == 2);
            redirect_pc = 32'h0000_0200;
            imem_rvalid = (i % 2 == 0);
            check("ma_halt_req", imem_req, 0);
            tick();
        end
        redirect = 1'b0; imem_rvalid = 1'b0;
        check("ma_sticky", misalign, 1);
        check("ma_halt_req_end", imem_req, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ma_rst_flag", misalign,  0);
        check("ma_rst_req",  imem_req,  1);
        check("ma_rst_addr", imem_addr, 0);

        // Reset while waiting; the late response must be ignored.
        tick();
        check("rw_wait_req", imem_req, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_req",  imem_req,  1);
        check("rw_addr", imem_addr, 0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("rw_ignored_valid", inst_valid, 0);
        tick();
        check("rw_still_waiting", inst_valid, 0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        check("rw_valid", inst_valid, 1);
        check("rw_inst",  inst,       32'h0050_0093);

        // PC wrap at the top of the address space.
        inst_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("wr_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_006F;
        tick();
        imem_rvalid = 1'b0;
        check("wr_pc",  pc,       32'hFFFF_FFFC);
        check("wr_pc4", pc_plus4, 32'h0000_0000);
        inst_ready = 1'b1;
        tick();
        check("wr_next_addr", imem_addr, 0);

        // Redirect during FETCH: request goes to old address, response dropped.
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        imem_rvalid = 1'b0;
        check("fr_valid", inst_valid, 0);
        check("fr_req",   imem_req,   1);
        check("fr_addr",  imem_addr,  32'h0000_0200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
